mmio_timer: RTL and testbench
=============================

// Module: mmio_timer
// PURPOSE
//  Memory-mapped timer responding on the core's data-memory interface (require / write_enable /
//  byte map / address / write data -> read data), decoded in a window above RAM. Provides a
//  prescaled 32-bit up-counter, compare match, periodic or one-shot mode and a level interrupt.
//  Sits beside RAM on the motherboard; a decoder steers core data accesses in its window here.
// PARAMETERS
//  BASE_ADDR  32'h0000_0100  byte address of register 0; window is BASE_ADDR..BASE_ADDR+0x13
//  PRESC_W    16             width of prescaler register and prescaler counter
// PORTS
//  clk                   in   1   single clock; all state updates on rising edge
//  reset                 in   1   asynchronous, active-high reset
//  data_require          in   1   access request from core
//  data_write_enable     in   1   1 = write, 0 = read (valid with data_require)
//  data_byte_enable_map  in   4   per-byte write strobes, bit n -> data_write[8n+7:8n]
//  data_address          in   32  byte address; bits [1:0] ignored
//  data_write            in   32  write data
//  data_read             out  32  read data, combinational, same cycle as request
//  irq                   out  1   STATUS.MATCH & CTRL.IE
// BEHAVIOUR
//  Register map (word offset): 0x00 CTRL {IE[2],ONESHOT[1],EN[0]}; 0x04 PRESCALE[PRESC_W-1:0];
//   0x08 COUNT[31:0]; 0x0C COMPARE[31:0]; 0x10 STATUS {MATCH[0]}, write-1-to-clear.
//  Reset: all registers 0, prescaler counter 0, state IDLE, irq 0, data_read 0.
//  Hit = data_require & (BASE_ADDR <= data_address < BASE_ADDR+0x14). No hit -> data_read = 0,
//   no state change. Unused register bits read 0, writes to them ignored.
//  Read: data_read = selected register in same cycle; reads have no side effects.
//  Write: on clock edge, only bytes with strobe set are updated; STATUS byte0 bit0 = 1 clears MATCH.
//  FSM: IDLE (EN=0) -> RUN when EN written 1. RUN -> IDLE when EN written 0 (prescaler counter
//   cleared, COUNT held). RUN -> DONE on match if ONESHOT=1 (hardware clears EN). DONE -> RUN on
//   EN write 1; DONE -> IDLE on any CTRL write with EN=0.
//  RUN: prescaler counter increments each cycle; when it equals PRESCALE -> tick, counter -> 0.
//   PRESCALE=0 gives a tick every cycle. On tick: if COUNT==COMPARE -> COUNT=0, MATCH=1; else
//   COUNT = COUNT+1, wrapping 32'hFFFF_FFFF -> 0 with no flag.
//  Simultaneous events: software COUNT write beats tick increment/clear same cycle; new match
//   beats W1C of MATCH same cycle (MATCH stays 1); software EN=1 write beats one-shot auto-clear.
//  Reset mid-run: immediate return to reset values, irq drops asynchronously.
// STRUCTURE
//  Package mmio_timer_pkg: register offset localparams, CTRL/STATUS bit indices, state enum
//   {IDLE, RUN, DONE}.
//  One sub-module: timer_prescaler (PRESC_W counter, enable, clear, PRESCALE in -> tick out).
//  Top holds address decode, byte-strobed register file, FSM, COUNT/compare logic, read mux.
// TESTING
//  1 Reset, read all 5 regs -> all 0; irq 0; read BASE_ADDR+0x20 -> 0.
//  2 PRESCALE=3, COMPARE=2, CTRL=1 -> COUNT 0,1,2 on every 4th cycle, then 0 with MATCH=1, repeats.
//  3 ONESHOT: CTRL=3, PRESCALE=0, COMPARE=5 -> MATCH after 6 ticks, CTRL reads 2, COUNT stays 0.
//  4 Byte strobes: COMPARE write 32'hAABBCCDD map 4'b0101 over 0 -> reads 32'h00BB00DD.
//  5 IE=1, MATCH set -> irq=1; write STATUS=1 -> irq 0; W1C on match cycle -> MATCH stays 1.
//  6 COUNT write 32'hFFFF_FFFF, COMPARE=1, run PRESCALE=0 -> 0 next tick, no MATCH; reset mid-run
//   -> all regs 0 before next edge.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// ---------------------------------------------------------------------------
// mmio_timer_pkg
// Shared definitions for the memory-mapped timer: register word offsets,
// CTRL/STATUS bit positions, the timer state enum and a byte-strobe helper.
// No ports; imported by the interface, the prescaler and the timer top.
// ---------------------------------------------------------------------------
package mmio_timer_pkg;

   // Word index of each register inside the timer window (byte offset >> 2)
   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PRESCALE = 3'd1;
   localparam logic [2:0] REG_COUNT    = 3'd2;
   localparam logic [2:0] REG_COMPARE  = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;

   // Size of the decoded window in bytes (five 32-bit registers)
   localparam logic [31:0] WINDOW_BYTES = 32'h0000_0014;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_IE      = 2;

   // STATUS bit positions
   localparam int STATUS_MATCH = 0;

   // Timer run state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timerState_t;

   // Expand the 4 byte strobes into a 32-bit bit mask so strobed writes
   // become a simple (old & ~mask) | (new & mask) merge
   function automatic logic [31:0] byteMask(input logic [3:0] be);
      byteMask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// ---------------------------------------------------------------------------
// mmio_timer_if
// Core data-memory bus as seen by the timer.
//   data_require          access request
//   data_write_enable     1 = write, 0 = read
//   data_byte_enable_map  per-byte write strobes
//   data_address          byte address
//   data_write            write data
//   data_read             read data (combinational from the slave)
// master modport: the core/decoder side; slave modport: the timer side.
// ---------------------------------------------------------------------------
interface mmio_timer_if;
   import mmio_timer_pkg::*;

   logic        data_require;
   logic        data_write_enable;
   logic [3:0]  data_byte_enable_map;
   logic [31:0] data_address;
   logic [31:0] data_write;
   logic [31:0] data_read;

   modport master (
      output data_require,
      output data_write_enable,
      output data_byte_enable_map,
      output data_address,
      output data_write,
      input  data_read
   );

   modport slave (
      input  data_require,
      input  data_write_enable,
      input  data_byte_enable_map,
      input  data_address,
      input  data_write,
      output data_read
   );

endinterface

// File: rtl/mmio_timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Free-running divider for the timer: counts cycles while enabled and emits
// a one-cycle tick when the count equals the programmed prescale value,
// then restarts from zero. A prescale of zero ticks every cycle.
// Ports:
//   clk         clock
//   reset       asynchronous active-high reset
//   enable_i    count this cycle
//   clear_i     force the counter back to zero (wins over enable)
//   prescale_i  terminal count
//   tick_o      combinational tick, valid in the cycle the count matches
// ---------------------------------------------------------------------------
module timer_prescaler
   import mmio_timer_pkg::*;
#(
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable_i,
   input  logic               clear_i,
   input  logic [PRESC_W-1:0] prescale_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] cnt_q;
   logic [PRESC_W-1:0] cnt_d;

   // Next count and tick: clear dominates, otherwise count up and wrap to
   // zero on the cycle that produces the tick
   always_comb begin
      cnt_d  = cnt_q;
      tick_o = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         if (cnt_q == prescale_i) begin
            tick_o = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// ---------------------------------------------------------------------------
// mmio_timer
// Memory-mapped 32-bit timer with prescaler, compare match, periodic or
// one-shot operation and a level interrupt.
// Registers (byte offset from BASE_ADDR):
//   0x00 CTRL     {IE[2], ONESHOT[1], EN[0]}
//   0x04 PRESCALE [PRESC_W-1:0]
//   0x08 COUNT    [31:0]
//   0x0C COMPARE  [31:0]
//   0x10 STATUS   {MATCH[0]}, write 1 to clear
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    core data-memory bus (slave side)
//   irq    STATUS.MATCH & CTRL.IE
// ---------------------------------------------------------------------------
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
   parameter int          PRESC_W   = 16
) (
   input  logic         clk,
   input  logic         reset,
   mmio_timer_if.slave  bus,
   output logic         irq
);

   logic [31:0]        offset;
   logic               hit;
   logic               wrEn;
   logic               rdEn;
   logic [2:0]         wordIdx;
   logic [31:0]        wrMask;
   logic               ctrlWr;
   logic               tick;
   logic               matchEvent;
   logic               autoClear;
   logic               running;

   logic               ctrlIe_q, ctrlIe_d;
   logic               ctrlOneshot_q, ctrlOneshot_d;
   logic               ctrlEn_q, ctrlEn_d;
   logic [PRESC_W-1:0] prescale_q, prescale_d;
   logic [31:0]        count_q, count_d;
   logic [31:0]        compare_q, compare_d;
   logic               match_q, match_d;
   timerState_t        state_q, state_d;

   // Address decode: subtracting the base makes addresses below the window
   // wrap to huge values, so one unsigned compare covers both window bounds
   always_comb begin
      offset  = bus.data_address - BASE_ADDR;
      hit     = bus.data_require && (offset < WINDOW_BYTES);
      wrEn    = hit && bus.data_write_enable;
      rdEn    = hit && !bus.data_write_enable;
      wordIdx = offset[4:2];
      wrMask  = byteMask(bus.data_byte_enable_map);
      ctrlWr  = wrEn && (wordIdx == REG_CTRL) && bus.data_byte_enable_map[0];
   end

   timer_prescaler #(
      .PRESC_W    (PRESC_W)
   ) u_prescaler (
      .clk        (clk),
      .reset      (reset),
      .enable_i   (running),
      .clear_i    (!running),
      .prescale_i (prescale_q),
      .tick_o     (tick)
   );

   // A match can only happen on a tick, and ticks only come while running
   always_comb begin
      matchEvent = tick && (count_q == compare_q);
      autoClear  = matchEvent && ctrlOneshot_q;
   end

   // FSM next state. In RUN a software EN=0 write stops the timer, and a
   // software EN=1 write in the same cycle as a one-shot match keeps it
   // running instead of letting hardware park it in DONE
   always_comb begin
      state_d = state_q;
      running = (state_q == RUN);
      case (state_q)
         IDLE: begin
            if (ctrlWr && bus.data_write[CTRL_EN]) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (ctrlWr && !bus.data_write[CTRL_EN]) begin
               state_d = IDLE;
            end else if (autoClear && !ctrlWr) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (ctrlWr) begin
               state_d = bus.data_write[CTRL_EN] ? RUN : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register file next values. The tick update of COUNT is computed first
   // so a software write to COUNT in the same cycle overrides it; the W1C of
   // MATCH is applied before a new match so the new match wins
   always_comb begin
      ctrlIe_d      = ctrlIe_q;
      ctrlOneshot_d = ctrlOneshot_q;
      ctrlEn_d      = ctrlEn_q;
      prescale_d    = prescale_q;
      count_d       = count_q;
      compare_d     = compare_q;
      match_d       = match_q;

      if (ctrlWr) begin
         ctrlIe_d      = bus.data_write[CTRL_IE];
         ctrlOneshot_d = bus.data_write[CTRL_ONESHOT];
         ctrlEn_d      = bus.data_write[CTRL_EN];
      end else if (autoClear) begin
         ctrlEn_d = 1'b0;
      end

      if (wrEn && (wordIdx == REG_PRESCALE)) begin
         prescale_d = (prescale_q & ~wrMask[PRESC_W-1:0])
                    | (bus.data_write[PRESC_W-1:0] & wrMask[PRESC_W-1:0]);
      end

      if (tick) begin
         count_d = matchEvent ? 32'd0 : count_q + 32'd1;
      end
      if (wrEn && (wordIdx == REG_COUNT)) begin
         count_d = (count_d & ~wrMask) | (bus.data_write & wrMask);
      end

      if (wrEn && (wordIdx == REG_COMPARE)) begin
         compare_d = (compare_q & ~wrMask) | (bus.data_write & wrMask);
      end

      if (wrEn && (wordIdx == REG_STATUS) && bus.data_byte_enable_map[0]
          && bus.data_write[STATUS_MATCH]) begin
         match_d = 1'b0;
      end
      if (matchEvent) begin
         match_d = 1'b1;
      end
   end

   // State and register storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ctrlIe_q      <= 1'b0;
         ctrlOneshot_q <= 1'b0;
         ctrlEn_q      <= 1'b0;
         prescale_q    <= '0;
         count_q       <= '0;
         compare_q     <= '0;
         match_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ctrlIe_q      <= ctrlIe_d;
         ctrlOneshot_q <= ctrlOneshot_d;
         ctrlEn_q      <= ctrlEn_d;
         prescale_q    <= prescale_d;
         count_q       <= count_d;
         compare_q     <= compare_d;
         match_q       <= match_d;
      end
   end

   // Read mux: only a read that hits the window drives data, everything
   // else (misses, writes, unused bits) reads as zero
   always_comb begin
      bus.data_read = 32'd0;
      if (rdEn) begin
         case (wordIdx)
            REG_CTRL:     bus.data_read = {29'd0, ctrlIe_q, ctrlOneshot_q, ctrlEn_q};
            REG_PRESCALE: bus.data_read = 32'(prescale_q);
            REG_COUNT:    bus.data_read = count_q;
            REG_COMPARE:  bus.data_read = compare_q;
            REG_STATUS:   bus.data_read = {31'd0, match_q};
            default:      bus.data_read = 32'd0;
         endcase
      end
   end

   // Level interrupt straight from registered state, so it drops as soon
   // as reset clears the registers
   assign irq = match_q && ctrlIe_q;

endmodule

// File: tb/tb_mmio_timer.sv
// ---------------------------------------------------------------------------
// tb_mmio_timer
// Self-checking bench for mmio_timer. Stimulus issues one bus access per
// cycle; every read pushes its expected data and irq level into a queue and
// a separate monitor pops and compares whenever a read is on the bus.
// ---------------------------------------------------------------------------
module tb_mmio_timer;
   import mmio_timer_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] A_CTRL     = BASE + 32'h00;
   localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
   localparam logic [31:0] A_COUNT    = BASE + 32'h08;
   localparam logic [31:0] A_COMPARE  = BASE + 32'h0C;
   localparam logic [31:0] A_STATUS   = BASE + 32'h10;

   typedef struct packed {
      logic [31:0] data;
      logic        irq;
   } expect_t;

   logic clk;
   logic reset;
   logic irq;

   expect_t expQ[$];
   string   nameQ[$];
   int      total;
   int      bad;

   mmio_timer_if bus();

   mmio_timer #(
      .BASE_ADDR (BASE),
      .PRESC_W   (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one popped expectation against what the DUT shows right now
   task automatic checkOutput(input string name, input expect_t e);
      total = total + 1;
      if (bus.data_read !== e.data) begin
         bad = bad + 1;
         $display("[TB] FAIL %s data: got %h want %h", name, bus.data_read, e.data);
      end
      total = total + 1;
      if (irq !== e.irq) begin
         bad = bad + 1;
         $display("[TB] FAIL %s irq: got %b want %b", name, irq, e.irq);
      end
   endtask

   // Monitor: mid-cycle, any read on the bus consumes one expectation
   always @(negedge clk) begin
      if (bus.data_require === 1'b1 && bus.data_write_enable === 1'b0) begin
         if (expQ.size() == 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL unexpected_read: got %h want no read", bus.data_read);
         end else begin
            checkOutput(nameQ.pop_front(), expQ.pop_front());
         end
      end
   end

   // One bus access lasting exactly one cycle; called just after a rising
   // edge and returns just after the next one
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be,
                                input logic [31:0] expData, input logic expIrq,
                                input string name);
      expect_t e;
      bus.data_require         = 1'b1;
      bus.data_write_enable    = isWrite;
      bus.data_address         = addr;
      bus.data_write           = data;
      bus.data_byte_enable_map = be;
      if (!isWrite) begin
         e.data = expData;
         e.irq  = expIrq;
         expQ.push_back(e);
         nameQ.push_back(name);
      end
      @(posedge clk);
      #1;
      bus.data_require      = 1'b0;
      bus.data_write_enable = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      applyStimulus(1'b1, addr, data, be, 32'd0, 1'b0, "write");
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] expData,
                     input logic expIrq, input string name);
      applyStimulus(1'b0, addr, 32'd0, 4'h0, expData, expIrq, name);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.data_require         = 1'b0;
      bus.data_write_enable    = 1'b0;
      bus.data_byte_enable_map = 4'h0;
      bus.data_address         = 32'd0;
      bus.data_write           = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset values and out-of-window reads
      rd(A_CTRL,     32'd0, 1'b0, "rst_ctrl");
      rd(A_PRESCALE, 32'd0, 1'b0, "rst_prescale");
      rd(A_COUNT,    32'd0, 1'b0, "rst_count");
      rd(A_COMPARE,  32'd0, 1'b0, "rst_compare");
      rd(A_STATUS,   32'd0, 1'b0, "rst_status");
      rd(BASE + 32'h14, 32'd0, 1'b0, "miss_above");
      rd(BASE + 32'h20, 32'd0, 1'b0, "miss_20");
      rd(BASE - 32'h4,  32'd0, 1'b0, "miss_below");

      // Periodic run: PRESCALE=3, COMPARE=2, count advances every 4th cycle
      wr(A_PRESCALE, 32'd3, 4'hF);
      wr(A_COMPARE,  32'd2, 4'hF);
      wr(A_CTRL,     32'd1, 4'hF);
      for (int k = 0; k < 20; k++) begin
         rd(A_COUNT, 32'((k / 4) % 3), 1'b0, $sformatf("periodic_count_%0d", k));
      end
      rd(A_STATUS, 32'd1, 1'b0, "periodic_match");
      wr(A_CTRL,   32'd0, 4'hF);
      wr(A_COUNT,  32'd0, 4'hF);
      wr(A_STATUS, 32'd1, 4'hF);
      rd(A_STATUS, 32'd0, 1'b0, "periodic_w1c");

      // One-shot: PRESCALE=0, COMPARE=5, match after 6 ticks then DONE
      wr(A_PRESCALE, 32'd0, 4'hF);
      wr(A_COMPARE,  32'd5, 4'hF);
      wr(A_CTRL,     32'd3, 4'hF);
      for (int k = 0; k < 6; k++) begin
         rd(A_COUNT, 32'(k), 1'b0, $sformatf("oneshot_count_%0d", k));
      end
      rd(A_CTRL,   32'd2, 1'b0, "oneshot_ctrl");
      rd(A_COUNT,  32'd0, 1'b0, "oneshot_count_held");
      rd(A_STATUS, 32'd1, 1'b0, "oneshot_match");
      rd(A_COUNT,  32'd0, 1'b0, "oneshot_count_still");
      wr(A_STATUS, 32'd1, 4'hF);
      wr(A_CTRL,   32'd0, 4'hF);
      rd(A_STATUS, 32'd0, 1'b0, "oneshot_w1c");

      // Byte strobes and unused bits
      wr(A_COMPARE,  32'd0, 4'hF);
      wr(A_COMPARE,  32'hAABB_CCDD, 4'b0101);
      rd(A_COMPARE,  32'h00BB_00DD, 1'b0, "strobe_compare");
      wr(A_PRESCALE, 32'hFFFF_1234, 4'hF);
      rd(A_PRESCALE, 32'h0000_1234, 1'b0, "prescale_width");
      wr(A_CTRL,     32'hFFFF_FFF8, 4'hF);
      rd(A_CTRL,     32'd0, 1'b0, "ctrl_unused");

      // Interrupt and W1C racing a new match
      wr(A_PRESCALE, 32'd0, 4'hF);
      wr(A_COMPARE,  32'd0, 4'hF);
      wr(A_COUNT,    32'd0, 4'hF);
      wr(A_CTRL,     32'd5, 4'hF);
      rd(A_COUNT,    32'd0, 1'b0, "irq_before_match");
      rd(A_STATUS,   32'd1, 1'b1, "irq_set");
      wr(A_STATUS,   32'd1, 4'hF);
      rd(A_STATUS,   32'd1, 1'b1, "w1c_vs_match");
      wr(A_CTRL,     32'd4, 4'hF);
      wr(A_STATUS,   32'd1, 4'hF);
      rd(A_STATUS,   32'd0, 1'b0, "irq_cleared");
      rd(A_CTRL,     32'd4, 1'b0, "irq_ctrl");

      // COUNT wrap without match, then reset in the middle of a run
      wr(A_COMPARE,  32'd1, 4'hF);
      wr(A_COUNT,    32'hFFFF_FFFF, 4'hF);
      wr(A_CTRL,     32'd5, 4'hF);
      rd(A_COUNT,    32'hFFFF_FFFF, 1'b0, "wrap_before");
      rd(A_COUNT,    32'd0, 1'b0, "wrap_after");
      rd(A_STATUS,   32'd0, 1'b0, "wrap_no_match");
      rd(A_STATUS,   32'd1, 1'b1, "match_after_wrap");
      reset = 1'b1;
      rd(A_CTRL,     32'd0, 1'b0, "midrst_ctrl");
      rd(A_PRESCALE, 32'd0, 1'b0, "midrst_prescale");
      rd(A_COUNT,    32'd0, 1'b0, "midrst_count");
      rd(A_COMPARE,  32'd0, 1'b0, "midrst_compare");
      rd(A_STATUS,   32'd0, 1'b0, "midrst_status");
      reset = 1'b0;
      rd(A_COUNT,    32'd0, 1'b0, "post_rst_count");

      // Every issued read must have been seen by the monitor
      repeat (3) @(posedge clk);
      total = total + 1;
      if (expQ.size() != 0) begin
         bad = bad + 1;
         $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
